// File: rtl/nes_mem_arbiter.sv
// Shared 22-bit game memory arbiter: loader > PPU > CPU, fixed wait states.
// Define NES_MEM_ARB_RR_EN for round-robin between PPU and CPU.
module nes_mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [21:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  output logic        ld_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        ppu_req,
  input  logic [21:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic        ppu_ack,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_oe,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  grant
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] G_LD  = 2'd1;
  localparam logic [1:0] G_PPU = 2'd2;
  localparam logic [1:0] G_CPU = 2'd3;

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  logic [1:0] state;
  logic [3:0] cnt;
  logic       pick_ppu;

`ifdef NES_MEM_ARB_RR_EN
  logic cpu_last;

  always_comb pick_ppu = ppu_req && (!cpu_req || cpu_last);

  // Loader grants leave the PPU/CPU fairness flag untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_last <= 1'b1;
    end else if (state == S_IDLE && !ld_req) begin
      if (pick_ppu)
        cpu_last <= 1'b0;
      else if (cpu_req)
        cpu_last <= 1'b1;
    end
  end
`else
  always_comb pick_ppu = ppu_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      grant     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      ld_ack    <= 1'b0;
      cpu_ack   <= 1'b0;
      ppu_ack   <= 1'b0;
      cpu_rdata <= '0;
      ppu_rdata <= '0;
    end else begin
      ld_ack  <= 1'b0;
      cpu_ack <= 1'b0;
      ppu_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= 4'(WAIT_CYCLES - 1);
          priority case (1'b1)
            ld_req: begin
              grant     <= G_LD;
              mem_addr  <= ld_addr;
              mem_wdata <= ld_wdata;
              mem_we    <= 1'b1;
              mem_oe    <= 1'b0;
              state     <= S_ACCESS;
            end
            pick_ppu: begin
              grant    <= G_PPU;
              mem_addr <= ppu_addr;
              mem_we   <= 1'b0;
              mem_oe   <= 1'b1;
              state    <= S_ACCESS;
            end
            cpu_req: begin
              grant     <= G_CPU;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_we    <= cpu_we;
              mem_oe    <= !cpu_we;
              state     <= S_ACCESS;
            end
            default: ;
          endcase
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            if (mem_oe) begin
              if (grant == G_PPU)
                ppu_rdata <= mem_rdata;
              else
                cpu_rdata <= mem_rdata;
            end
            ld_ack  <= (grant == G_LD);
            ppu_ack <= (grant == G_PPU);
            cpu_ack <= (grant == G_CPU);
            mem_we  <= 1'b0;
            mem_oe  <= 1'b0;
            grant   <= '0;
            state   <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Directed bench for nes_mem_arbiter: vector table plus corner sequences.
// Uses a WAIT_CYCLES=2 instance and a WAIT_CYCLES=1 instance.
module tb_nes_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic ld_req = 0, cpu_req = 0, cpu_we = 0, ppu_req = 0;
  logic [21:0] ld_addr = 0, cpu_addr = 0, ppu_addr = 0;
  logic [7:0] ld_wdata = 0, cpu_wdata = 0, mem_rdata = 0;
  logic ld_ack, cpu_ack, ppu_ack, mem_we, mem_oe;
  logic [7:0] cpu_rdata, ppu_rdata, mem_wdata;
  logic [21:0] mem_addr;
  logic [1:0] grant;

  logic b_ld_req = 0, b_cpu_req = 0, b_cpu_we = 0, b_ppu_req = 0;
  logic [21:0] b_ld_addr = 0, b_cpu_addr = 0, b_ppu_addr = 0;
  logic [7:0] b_ld_wdata = 0, b_cpu_wdata = 0, b_mem_rdata = 0;
  logic b_ld_ack, b_cpu_ack, b_ppu_ack, b_mem_we, b_mem_oe;
  logic [7:0] b_cpu_rdata, b_ppu_rdata, b_mem_wdata;
  logic [21:0] b_mem_addr;
  logic [1:0] b_grant;

  nes_mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
    .ppu_ack(ppu_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_oe(mem_oe), .mem_rdata(mem_rdata), .grant(grant)
  );

  nes_mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .ld_req(b_ld_req), .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata),
    .ld_ack(b_ld_ack),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata),
    .cpu_ack(b_cpu_ack),
    .ppu_req(b_ppu_req), .ppu_addr(b_ppu_addr),
    .ppu_rdata(b_ppu_rdata), .ppu_ack(b_ppu_ack),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_oe(b_mem_oe), .mem_rdata(b_mem_rdata), .grant(b_grant)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    int          src;
    logic        we;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mdata;
    logic [1:0]  exp_grant;
    logic        exp_we;
    logic        exp_oe;
    logic [2:0]  exp_ack;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vec[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ld_req = 0; cpu_req = 0; ppu_req = 0;
    b_ld_req = 0; b_cpu_req = 0; b_ppu_req = 0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [2:0] acks();
    return {ld_ack, ppu_ack, cpu_ack};
  endfunction

  initial begin
    int exp_g[5];
    int n;
    int cnt;
    int we_run;
    int last;
    int nacks;

    vec[0] = '{1, 1'b1, 22'h000010, 8'h4C, 8'h00,
               2'd1, 1'b1, 1'b0, 3'b100, 8'h00};
    vec[1] = '{3, 1'b0, 22'h000123, 8'h00, 8'hA9,
               2'd3, 1'b0, 1'b1, 3'b001, 8'hA9};
    vec[2] = '{3, 1'b1, 22'h1FFFFF, 8'h55, 8'h77,
               2'd3, 1'b1, 1'b0, 3'b001, 8'h00};
    vec[3] = '{2, 1'b0, 22'h200000, 8'h00, 8'h3C,
               2'd2, 1'b0, 1'b1, 3'b010, 8'h3C};
    vec[4] = '{2, 1'b0, 22'h3FFFFF, 8'h00, 8'hE7,
               2'd2, 1'b0, 1'b1, 3'b010, 8'hE7};

    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_we_oe", {mem_we, mem_oe}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_acks", acks(), 0);
    chk("rst_rdata", {cpu_rdata, ppu_rdata}, 0);
    chk("rst_b_grant", {b_grant, b_mem_we, b_cpu_ack}, 0);

    for (int i = 0; i < 5; i++) begin
      mem_rdata = vec[i].mdata;
      unique case (vec[i].src)
        1: begin
          ld_req = 1; ld_addr = vec[i].addr; ld_wdata = vec[i].wdata;
        end
        2: begin
          ppu_req = 1; ppu_addr = vec[i].addr;
        end
        default: begin
          cpu_req = 1; cpu_we = vec[i].we;
          cpu_addr = vec[i].addr; cpu_wdata = vec[i].wdata;
        end
      endcase
      for (int k = 1; k <= 2; k++) begin
        cyc();
        chk($sformatf("v%0d_grant_c%0d", i, k), grant, vec[i].exp_grant);
        chk($sformatf("v%0d_addr_c%0d", i, k), mem_addr, vec[i].addr);
        chk($sformatf("v%0d_we_c%0d", i, k), mem_we, vec[i].exp_we);
        chk($sformatf("v%0d_oe_c%0d", i, k), mem_oe, vec[i].exp_oe);
        chk($sformatf("v%0d_noack_c%0d", i, k), acks(), 0);
        if (vec[i].exp_we)
          chk($sformatf("v%0d_wdata_c%0d", i, k), mem_wdata,
              vec[i].wdata);
      end
      cyc();
      chk($sformatf("v%0d_ack", i), acks(), vec[i].exp_ack);
      chk($sformatf("v%0d_done_bus", i), {grant, mem_we, mem_oe}, 0);
      if (vec[i].exp_oe)
        chk($sformatf("v%0d_rdata", i),
            vec[i].src == 2 ? ppu_rdata : cpu_rdata, vec[i].exp_rdata);
      ld_req = 0; cpu_req = 0; ppu_req = 0;
      cyc();
      chk($sformatf("v%0d_ack_gone", i), acks(), 0);
    end

    repeat (10) cyc();
    chk("cpu_rdata_hold", cpu_rdata, 8'hA9);
    chk("ppu_rdata_hold", ppu_rdata, 8'hE7);

    // Simultaneous requests; CPU and PPU stay asserted throughout
    do_reset();
`ifdef NES_MEM_ARB_RR_EN
    exp_g = '{1, 2, 3, 2, 3};
`else
    exp_g = '{1, 2, 2, 2, 2};
`endif
    ld_req = 1; ld_addr = 22'h000001; ld_wdata = 8'h01;
    cpu_req = 1; cpu_we = 0; cpu_addr = 22'h000002;
    ppu_req = 1; ppu_addr = 22'h200002;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (grant == 0 && n < 10) begin cyc(); n++; end
      chk($sformatf("arb_grant%0d", g), grant, exp_g[g]);
      n = 0;
      while (acks() == 0 && n < 10) begin cyc(); n++; end
      chk($sformatf("arb_ack%0d", g), acks() != 0, 1);
      if (ld_ack) ld_req = 0;
    end

    // Address change and stale request during an access are ignored
    do_reset();
    mem_rdata = 8'h11;
    ppu_req = 1; ppu_addr = 22'h200000;
    cyc();
    ppu_addr = 22'h2000FF;
    chk("stale_addr_c1", mem_addr, 22'h200000);
    cyc();
    chk("stale_addr_c2", mem_addr, 22'h200000);
    cyc();
    chk("stale_ack", ppu_ack, 1);
    chk("stale_rdata", ppu_rdata, 8'h11);
    cyc();
    ppu_req = 0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (ppu_ack || grant != 0) cnt++;
      cyc();
    end
    chk("stale_no_regrant", cnt, 0);

    // Reset in the first access cycle of a CPU write
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 22'h000042; cpu_wdata = 8'h99;
    cyc();
    chk("rmid_grant", grant, 3);
    chk("rmid_we", mem_we, 1);
    reset = 1;
    cyc();
    chk("rmid_after", {grant, mem_we, mem_oe}, 0);
    reset = 0;
    cpu_req = 0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (cpu_ack) cnt++;
      cyc();
    end
    chk("rmid_no_ack", cnt, 0);

    // WAIT_CYCLES=1 back-to-back CPU writes
    do_reset();
    b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 22'h000300;
    b_cpu_wdata = 8'h5A;
    we_run = 0;
    last = -1;
    nacks = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (b_mem_we) we_run++;
      if (b_cpu_ack) begin
        chk($sformatf("w1_we_len%0d", nacks), we_run, 1);
        if (last >= 0)
          chk($sformatf("w1_gap%0d", nacks), c - last, 3);
        we_run = 0;
        last = c;
        nacks++;
      end
    end
    chk("w1_ack_count", nacks, 13);
    b_cpu_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
